mips_multicycle_sequencer: RTL

Multi-cycle control sequencer for the single-issue MIPS datapath (register file, ALU, ALU control, data memory, operand muxes). It accepts one instruction per `newinstr` handshake and latches the opcode. It then steps through DECODE, EXEC, memory and write-back states. From these states it drives the datapath select lines and generates clean rising-edge strobes for the edge-triggered register file and data memory, and it reports completion and retired-instruction count.

---
 rtl/mips_multicycle_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle control sequencer for a single-issue MIPS datapath (R-type, addi, lw, sw).
// Latency: 5 cycles for R-type/addi, 5+MEM_LAT for lw, 4+MEM_LAT for sw, 3 for illegal (accept to IDLE).
// Backpressure: one instruction in flight; newinstr is ignored while busy (no queueing).
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   newinstr, opcode  - instruction-valid pulse and instrword[31:26], sampled only when accepted in IDLE
//   busy, done        - not-IDLE flag and one-cycle completion pulse
//   illegal           - last accepted opcode was unsupported (sticky until the next accept)
//   reg_write, mem_read, mem_write - clean single-edge strobes for the register file and data memory
//   mem_to_reg, reg_dst, alu_src, alu_op - datapath selects for the latched opcode
//   instr_count       - retired-instruction counter, wraps modulo 2^COUNT_W
module mips_multicycle_sequencer #(
    parameter int MEM_LAT = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               newinstr,
    input  logic [5:0]         opcode,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               alu_src,
    output logic [1:0]         alu_op,
    output logic [COUNT_W-1:0] instr_count
);

    // A latency below one cycle makes no sense for the memory; clamp it.
    localparam int LAT    = (MEM_LAT < 1) ? 1 : MEM_LAT;
    localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Select bundle: {mem_to_reg, reg_dst, alu_src, alu_op[1:0]}.
    function automatic logic [4:0] sel_of(input logic [5:0] op);
        logic [4:0] s;
        s = 5'b0_0_0_00;
        case (op)
            OP_RTYPE: s = 5'b0_1_0_10;
            OP_ADDI:  s = 5'b0_0_1_00;
            OP_LW:    s = 5'b1_0_1_00;
            OP_SW:    s = 5'b0_0_1_00;
            default:  s = 5'b0_0_0_00;   // unsupported: everything parked at 0
        endcase
        return s;
    endfunction

    function automatic logic supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    // Architectural state
    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // Registered outputs
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [4:0]         sel_q, sel_d;

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                if (newinstr) begin
                    op_d      = opcode;
                    illegal_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!supported(op_q)) begin
                    illegal_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_LW: begin
                        state_d = S_MEM_RD;
                        wait_d  = WAIT_LOAD;
                    end
                    OP_SW: begin
                        state_d = S_MEM_WR;
                        wait_d  = WAIT_LOAD;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM_RD: begin
                // Stay for LAT cycles total; leave on the cycle the counter reads 0.
                if (wait_q == '0) state_d = S_WB;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_MEM_WR: begin
                if (wait_q == '0) state_d = S_DONE;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_WB: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!illegal_q) count_d = count_q + COUNT_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so that, once registered, they line
    // up exactly with the state they describe while coming straight from flops.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        reg_write_d = (state_d == S_WB);
        mem_read_d  = (state_d == S_MEM_RD);
        mem_write_d = (state_d == S_MEM_WR);
        sel_d       = (state_d == S_IDLE) ? 5'b0 : sel_of(op_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 6'd0;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            sel_q       <= 5'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            sel_q       <= sel_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign reg_write   = reg_write_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_to_reg  = sel_q[4];
    assign reg_dst     = sel_q[3];
    assign alu_src     = sel_q[2];
    assign alu_op      = sel_q[1:0];
    assign instr_count = count_q;

endmodule
